// File: rtl/udp_wave_unpack.sv
// Unpacks UDP wave frames (MAGIC, seq, then big-endian 16-bit samples) into a sample strobe stream.
// Optional macro SEQ_CHECK_EN adds per-source sequence tracking and the lost-frame counter.
module udp_wave_unpack #(
  parameter logic [7:0] MAGIC   = 8'hA5,
  parameter int         MAX_SMP = 512
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        rec_en,
  input  logic [7:0]  rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  input  logic [1:0]  wave_source,
  output logic        smp_valid,
  output logic [15:0] smp_data,
  output logic [1:0]  smp_src,
  output logic [9:0]  smp_idx,
  output logic        frame_done,
  output logic        frame_err,
  output logic [9:0]  smp_cnt,
  output logic [15:0] lost_cnt
);
  typedef enum logic [2:0] {IDLE, SEQ, HI, LO, DROP} state_e;
  localparam logic [9:0] MAX_IDX = 10'(MAX_SMP);

  state_e      st_q, st_byte, st_d;
  logic [1:0]  src_q, src_d;
  logic [7:0]  hi_q, hi_d;
  logic [9:0]  idx_q, idx_byte, idx_d;
  logic        emit, close, clean;
  logic        smp_valid_q, frame_done_q, frame_err_q;
  logic [15:0] smp_data_q;
  logic [9:0]  smp_idx_q, smp_cnt_q;

  always_ff @(posedge gmii_rx_clk or negedge rst_n)
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;

  // st_byte is the state after consuming this cycle's byte; a coincident
  // rec_pkt_done then closes the frame based on that updated state.
  always_comb begin
    st_byte = st_q;
    src_d   = src_q;
    hi_d    = hi_q;
    if (rec_en) begin
      case (st_q)
        IDLE: begin
          src_d   = wave_source;
          st_byte = (rec_data == MAGIC && (wave_source == 2'b01 || wave_source == 2'b10))
                    ? SEQ : DROP;
        end
        SEQ:     st_byte = HI;
        HI: begin
          hi_d    = rec_data;
          st_byte = LO;
        end
        LO:      st_byte = (idx_q == MAX_IDX) ? DROP : HI;
        default: st_byte = st_q;
      endcase
    end
    st_d = rec_pkt_done ? IDLE : st_byte;
  end

  always_comb begin
    emit     = rec_en && (st_q == LO) && (idx_q != MAX_IDX);
    idx_byte = emit ? idx_q + 10'd1 : idx_q;
    idx_d    = rec_pkt_done ? '0 : idx_byte;
    close    = rec_pkt_done && (st_byte != IDLE);
    clean    = close && (st_byte == HI) && (idx_byte != '0) &&
               (rec_byte_num == 16'd2 + {5'd0, idx_byte, 1'b0});
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n)
    if (!rst_n) begin
      src_q        <= '0;
      hi_q         <= '0;
      idx_q        <= '0;
      smp_valid_q  <= 1'b0;
      smp_data_q   <= '0;
      smp_idx_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      smp_cnt_q    <= '0;
    end else begin
      src_q        <= src_d;
      hi_q         <= hi_d;
      idx_q        <= idx_d;
      smp_valid_q  <= emit;
      frame_done_q <= clean;
      frame_err_q  <= close && !clean;
      if (emit) begin
        smp_data_q <= {hi_q, rec_data};
        smp_idx_q  <= idx_q;
      end
      if (close) smp_cnt_q <= idx_byte;
    end

  assign smp_valid  = smp_valid_q;
  assign smp_data   = smp_data_q;
  assign smp_src    = src_q;
  assign smp_idx    = smp_idx_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign smp_cnt    = smp_cnt_q;

`ifdef SEQ_CHECK_EN
  logic [7:0]  seq_q, exp_a_q, exp_b_q, gap;
  logic        init_a_q, init_b_q, known;
  logic [15:0] lost_q;
  logic [16:0] sum;

  // Loss is counted and the expectation advanced only on clean frames.
  always_comb begin
    known = (src_q == 2'b01) ? init_a_q : init_b_q;
    gap   = seq_q - ((src_q == 2'b01) ? exp_a_q : exp_b_q);
    sum   = {1'b0, lost_q} + {9'd0, gap};
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n)
    if (!rst_n) begin
      seq_q    <= '0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      init_a_q <= 1'b0;
      init_b_q <= 1'b0;
      lost_q   <= '0;
    end else begin
      if (rec_en && st_q == SEQ) seq_q <= rec_data;
      if (clean) begin
        if (known) lost_q <= sum[16] ? 16'hFFFF : sum[15:0];
        if (src_q == 2'b01) begin
          exp_a_q  <= seq_q + 8'd1;
          init_a_q <= 1'b1;
        end else begin
          exp_b_q  <= seq_q + 8'd1;
          init_b_q <= 1'b1;
        end
      end
    end

  assign lost_cnt = lost_q;
`else
  assign lost_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_wave_unpack.sv
// Directed bench for udp_wave_unpack: hand-computed frames, strobes recorded by a negedge monitor.
module tb_udp_wave_unpack;
  logic        gmii_rx_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rec_en = 1'b0;
  logic [7:0]  rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic [1:0]  wave_source = '0;
  logic        smp_valid, frame_done, frame_err;
  logic [15:0] smp_data, lost_cnt;
  logic [1:0]  smp_src;
  logic [9:0]  smp_idx, smp_cnt;

  int checks = 0;
  int errors = 0;

  udp_wave_unpack dut (
    .gmii_rx_clk (gmii_rx_clk),
    .rst_n       (rst_n),
    .rec_en      (rec_en),
    .rec_data    (rec_data),
    .rec_pkt_done(rec_pkt_done),
    .rec_byte_num(rec_byte_num),
    .wave_source (wave_source),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_src     (smp_src),
    .smp_idx     (smp_idx),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .smp_cnt     (smp_cnt),
    .lost_cnt    (lost_cnt)
  );

  always #4 gmii_rx_clk = ~gmii_rx_clk;

  logic [15:0] sd_q[$];
  logic [9:0]  si_q[$];
  logic [1:0]  ss_q[$];
  int          n_done = 0, n_err = 0, n_both = 0;
  logic [9:0]  last_cnt = '0;
  logic [7:0]  fb[$];

  always @(negedge gmii_rx_clk) begin
    if (smp_valid) begin
      sd_q.push_back(smp_data);
      si_q.push_back(smp_idx);
      ss_q.push_back(smp_src);
    end
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (frame_done && frame_err) n_both++;
    if (frame_done || frame_err) last_cnt = smp_cnt;
  end

  task automatic clear_mon();
    sd_q.delete(); si_q.delete(); ss_q.delete();
    n_done = 0; n_err = 0; last_cnt = '0;
  endtask

  task automatic drive(input logic en, input logic [7:0] d, input logic done, input logic [15:0] num);
    @(negedge gmii_rx_clk);
    rec_en = en; rec_data = d; rec_pkt_done = done; rec_byte_num = num;
  endtask

  task automatic send_frame(input logic [1:0] src, input logic [15:0] num, input bit done_last);
    wave_source = src;
    for (int i = 0; i < fb.size(); i++)
      drive(1'b1, fb[i], done_last && (i == fb.size() - 1), num);
    if (!done_last) drive(1'b0, 8'h00, 1'b1, num);
    repeat (3) drive(1'b0, 8'h00, 1'b0, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge gmii_rx_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge gmii_rx_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rec_en = 1'b1; rec_data = 8'hA5; wave_source = 2'b01; rec_pkt_done = 1'b1;
    repeat (3) @(negedge gmii_rx_clk);
    checks++;
    if ({smp_valid, frame_done, frame_err, smp_data, smp_src, smp_idx, smp_cnt, lost_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v%b d%b e%b data %h src %h idx %0d cnt %0d lost %0d, need all 0",
               smp_valid, frame_done, frame_err, smp_data, smp_src, smp_idx, smp_cnt, lost_cnt);
    end
    rec_en = 1'b0; rec_pkt_done = 1'b0;
    @(negedge gmii_rx_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_mon();
    wave_source = 2'b01;
    drive(1'b1, 8'hA5, 1'b0, 16'd6);
    drive(1'b1, 8'h07, 1'b0, 16'd6);
    wave_source = 2'b10;  // mid-frame change must not leak into smp_src
    drive(1'b1, 8'h12, 1'b0, 16'd6);
    drive(1'b1, 8'h34, 1'b0, 16'd6);
    drive(1'b1, 8'hAB, 1'b0, 16'd6);
    checks++;
    if ({smp_valid, smp_data, smp_idx, smp_src} !== {1'b1, 16'h1234, 10'd0, 2'b01}) begin
      errors++;
      $display("FAIL basic_smp0 got v%b %h idx %0d src %b, need v1 1234 idx 0 src 01",
               smp_valid, smp_data, smp_idx, smp_src);
    end
    drive(1'b1, 8'hCD, 1'b1, 16'd6);
    drive(1'b0, 8'h00, 1'b0, 16'd0);
    checks++;
    if ({smp_valid, smp_data, smp_idx, smp_src} !== {1'b1, 16'hABCD, 10'd1, 2'b01}) begin
      errors++;
      $display("FAIL basic_smp1 got v%b %h idx %0d src %b, need v1 abcd idx 1 src 01",
               smp_valid, smp_data, smp_idx, smp_src);
    end
    checks++;
    if ({frame_done, frame_err, smp_cnt} !== {1'b1, 1'b0, 10'd2}) begin
      errors++;
      $display("FAIL basic_close got done %b err %b cnt %0d, need done 1 err 0 cnt 2",
               frame_done, frame_err, smp_cnt);
    end
    drive(1'b0, 8'h00, 1'b0, 16'd0);
    checks++;
    if ({smp_valid, frame_done, frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL basic_oneshot got v%b d%b e%b, need 000", smp_valid, frame_done, frame_err);
    end
    drive(1'b0, 8'h00, 1'b0, 16'd0);
    checks++;
    if (sd_q.size() != 2 || n_done != 1 || n_err != 0) begin
      errors++;
      $display("FAIL basic_counts got smp %0d done %0d err %0d, need 2 1 0", sd_q.size(), n_done, n_err);
    end
  endtask

  task automatic test_malformed();
    clear_mon();
    fb = {8'h5A, 8'h07, 8'h12, 8'h34};
    send_frame(2'b01, 16'd4, 1'b1);
    checks++;
    if (sd_q.size() != 0 || n_err != 1 || n_done != 0) begin
      errors++;
      $display("FAIL bad_magic got smp %0d err %0d done %0d, need 0 1 0", sd_q.size(), n_err, n_done);
    end
    clear_mon();
    fb = {8'hA5, 8'h07, 8'h12, 8'h34};
    send_frame(2'b11, 16'd4, 1'b1);
    checks++;
    if (sd_q.size() != 0 || n_err != 1 || n_done != 0) begin
      errors++;
      $display("FAIL bad_source got smp %0d err %0d done %0d, need 0 1 0", sd_q.size(), n_err, n_done);
    end
    clear_mon();
    fb = {8'hA5, 8'h00, 8'h12};
    send_frame(2'b01, 16'd3, 1'b1);
    checks++;
    if (n_err != 1 || n_done != 0 || last_cnt != 10'd0) begin
      errors++;
      $display("FAIL odd_payload got err %0d done %0d cnt %0d, need 1 0 0", n_err, n_done, last_cnt);
    end
    clear_mon();
    fb = {8'hA5, 8'h07, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_frame(2'b01, 16'd8, 1'b1);
    checks++;
    if (sd_q.size() != 2 || n_err != 1 || n_done != 0 || last_cnt != 10'd2) begin
      errors++;
      $display("FAIL bytenum_mismatch got smp %0d err %0d done %0d cnt %0d, need 2 1 0 2",
               sd_q.size(), n_err, n_done, last_cnt);
    end
    clear_mon();
    fb = {8'hA5};
    send_frame(2'b10, 16'd1, 1'b1);
    checks++;
    if (n_err != 1 || n_done != 0) begin
      errors++;
      $display("FAIL close_in_seq got err %0d done %0d, need 1 0", n_err, n_done);
    end
    clear_mon();
    fb = {8'hA5, 8'h00};
    send_frame(2'b10, 16'd2, 1'b1);
    checks++;
    if (n_err != 1 || n_done != 0 || last_cnt != 10'd0) begin
      errors++;
      $display("FAIL zero_samples got err %0d done %0d cnt %0d, need 1 0 0", n_err, n_done, last_cnt);
    end
  endtask

  task automatic test_separate_done();
    clear_mon();
    fb = {8'hA5, 8'h03, 8'h11, 8'h22};
    send_frame(2'b10, 16'd4, 1'b0);
    checks++;
    if (n_done != 1 || n_err != 0 || last_cnt != 10'd1 || sd_q.size() != 1 || ss_q[0] != 2'b10) begin
      errors++;
      $display("FAIL separate_done got done %0d err %0d cnt %0d smp %0d, need 1 0 1 1",
               n_done, n_err, last_cnt, sd_q.size());
    end
    clear_mon();
    drive(1'b0, 8'h00, 1'b1, 16'd0);
    repeat (3) drive(1'b0, 8'h00, 1'b0, 16'd0);
    checks++;
    if (n_done + n_err != 0) begin
      errors++;
      $display("FAIL idle_pkt_done got strobes %0d, need 0", n_done + n_err);
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    fb = {8'hA5, 8'h01};
    for (int i = 0; i < 513; i++) begin
      fb.push_back(8'(i >> 8));
      fb.push_back(8'(i));
    end
    send_frame(2'b01, 16'd1028, 1'b1);
    checks++;
    if (sd_q.size() != 512 || n_err != 1 || n_done != 0 || last_cnt != 10'd512) begin
      errors++;
      $display("FAIL overrun got smp %0d err %0d done %0d cnt %0d, need 512 1 0 512",
               sd_q.size(), n_err, n_done, last_cnt);
    end
    checks++;
    if (sd_q.size() == 512 && (si_q[511] != 10'd511 || sd_q[511] != 16'h01FF)) begin
      errors++;
      $display("FAIL overrun_last got idx %0d data %h, need 511 01ff", si_q[511], sd_q[511]);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    wave_source = 2'b01;
    drive(1'b1, 8'hA5, 1'b0, 16'd6);
    drive(1'b1, 8'h01, 1'b0, 16'd6);
    drive(1'b1, 8'h12, 1'b0, 16'd6);
    @(negedge gmii_rx_clk);
    rst_n = 1'b0; rec_en = 1'b0;
    @(negedge gmii_rx_clk);
    checks++;
    if ({smp_valid, frame_done, frame_err, smp_data, smp_src, smp_cnt, lost_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got v%b d%b e%b data %h src %b, need all 0",
               smp_valid, frame_done, frame_err, smp_data, smp_src);
    end
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 8'h00, 1'b0, 16'd0);
    checks++;
    if (sd_q.size() != 0 || n_done + n_err != 0) begin
      errors++;
      $display("FAIL reset_mid_strobe got smp %0d strobes %0d, need 0 0", sd_q.size(), n_done + n_err);
    end
    fb = {8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_frame(2'b01, 16'd6, 1'b1);
    checks++;
    if (n_done != 1 || n_err != 0 || sd_q.size() != 2 || sd_q[0] != 16'h1234) begin
      errors++;
      $display("FAIL reset_mid_recover got done %0d err %0d smp %0d, need 1 0 2", n_done, n_err, sd_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    fb = {8'hA5, 8'h01, 8'h11, 8'h22, 8'hA5, 8'h02, 8'h33, 8'h44, 8'h55, 8'h66};
    wave_source = 2'b01;
    for (int i = 0; i < 4; i++) drive(1'b1, fb[i], i == 3, 16'd4);
    wave_source = 2'b10;
    for (int i = 4; i < 10; i++) drive(1'b1, fb[i], i == 9, 16'd6);
    repeat (3) drive(1'b0, 8'h00, 1'b0, 16'd0);
    checks++;
    if (n_done != 2 || n_err != 0 || sd_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_counts got done %0d err %0d smp %0d, need 2 0 3", n_done, n_err, sd_q.size());
    end else begin
      checks++;
      if ({sd_q[0], si_q[0], ss_q[0], sd_q[1], si_q[1], ss_q[1], sd_q[2], si_q[2], ss_q[2]} !==
          {16'h1122, 10'd0, 2'b01, 16'h3344, 10'd0, 2'b10, 16'h5566, 10'd1, 2'b10}) begin
        errors++;
        $display("FAIL b2b_samples got %h/%0d/%b %h/%0d/%b %h/%0d/%b, need 1122/0/01 3344/0/10 5566/1/10",
                 sd_q[0], si_q[0], ss_q[0], sd_q[1], si_q[1], ss_q[1], sd_q[2], si_q[2], ss_q[2]);
      end
    end
  endtask

  task automatic test_lost_cnt();
    do_reset();
`ifdef SEQ_CHECK_EN
    fb = {8'hA5, 8'h03, 8'h12, 8'h34}; send_frame(2'b10, 16'd4, 1'b1);
    fb = {8'hA5, 8'h09, 8'h12, 8'h34}; send_frame(2'b01, 16'd4, 1'b1);
    fb = {8'hA5, 8'h0A, 8'h12, 8'h34}; send_frame(2'b01, 16'd4, 1'b1);
    checks++;
    if (lost_cnt !== 16'd0) begin
      errors++;
      $display("FAIL seq_first got lost %0d, need 0", lost_cnt);
    end
    fb = {8'hA5, 8'h06, 8'h12, 8'h34}; send_frame(2'b10, 16'd4, 1'b1);
    checks++;
    if (lost_cnt !== 16'd2) begin
      errors++;
      $display("FAIL seq_gap got lost %0d, need 2", lost_cnt);
    end
    fb = {8'hA5, 8'h20, 8'h12}; send_frame(2'b10, 16'd3, 1'b1);
    checks++;
    if (lost_cnt !== 16'd2) begin
      errors++;
      $display("FAIL seq_err_frame got lost %0d, need 2", lost_cnt);
    end
`else
    fb = {8'hA5, 8'h03, 8'h12, 8'h34}; send_frame(2'b10, 16'd4, 1'b1);
    fb = {8'hA5, 8'h09, 8'h12, 8'h34}; send_frame(2'b10, 16'd4, 1'b1);
    checks++;
    if (lost_cnt !== 16'd0) begin
      errors++;
      $display("FAIL lost_disabled got lost %0d, need 0", lost_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_malformed();
    test_separate_done();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_lost_cnt();
    checks++;
    if (n_both != 0) begin
      errors++;
      $display("FAIL done_err_exclusive got %0d overlaps, need 0", n_both);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
